costas_loop_filter: RTL and testbench

COSTAS_LOOP_FILTER -- requirements
Module: costas_loop_filter

---
 rtl/costas_loop_filter_if.sv | 23 ++
 rtl/costas_loop_filter.sv | 153 +++++++++++++++
 tb/tb_costas_loop_filter.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/costas_loop_filter_if.sv
// Sample/correction bus of the Costas loop filter: phase-error samples in,
// registered NCO correction plus lock and saturation status out.
interface costas_loop_filter_if #(
  parameter int ERR_W = 64,
  parameter int OUT_W = 32
);
  logic                    err_valid;
  logic signed [ERR_W-1:0] err_in;
  logic                    out_valid;
  logic signed [OUT_W-1:0] correction;
  logic                    locked;
  logic                    sat_flag;

  modport master (
    output err_valid, err_in,
    input  out_valid, correction, locked, sat_flag
  );

  modport slave (
    input  err_valid, err_in,
    output out_valid, correction, locked, sat_flag
  );
endinterface

// File: rtl/costas_loop_filter.sv
// Costas loop PI filter: ACQ/TRACK lock FSM picks the gain shifts, saturating integrator.
// Define COSTAS_LF_ROUND_EN for round-half-up gain shifts; the default build truncates.
module costas_loop_filter #(
  parameter int ERR_W    = 64,
  parameter int OUT_W    = 32,
  parameter int ACC_W    = 40,
  parameter int LOCK_CNT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  costas_loop_filter_if.slave bus,
  input  logic [5:0]          acq_kp_shift,
  input  logic [5:0]          acq_ki_shift,
  input  logic [5:0]          trk_kp_shift,
  input  logic [5:0]          trk_ki_shift,
  input  logic [ERR_W-2:0]    lock_thresh,
  input  logic                integ_clr,
  input  logic                freeze
);

  localparam int MAX_W = (ERR_W > ACC_W) ? ((ERR_W > OUT_W) ? ERR_W : OUT_W)
                                         : ((ACC_W > OUT_W) ? ACC_W : OUT_W);
  localparam int WIDE  = MAX_W + 2;
  localparam int CNT_W = $clog2(LOCK_CNT + 1);

  localparam logic signed [WIDE-1:0] ACC_MAX = {{(WIDE-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [WIDE-1:0] ACC_MIN = {{(WIDE-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
  localparam logic signed [WIDE-1:0] OUT_MAX = {{(WIDE-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [WIDE-1:0] OUT_MIN = {{(WIDE-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic {ACQ, TRACK} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        lock_cnt;
  logic                    v1;
  logic signed [ERR_W-1:0] p_r;
  logic signed [ERR_W-1:0] inc_r;
  logic signed [ACC_W-1:0] acc;

  logic [5:0]              kp_sel;
  logic [5:0]              ki_sel;
  logic [ERR_W-2:0]        mag;
  logic                    hit;
  logic signed [WIDE-1:0]  acc_sum;
  logic signed [WIDE-1:0]  corr_sum;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [OUT_W-1:0] corr_next;
  logic                    acc_clip;
  logic                    corr_clip;

  function automatic logic signed [ERR_W-1:0] gain_shift(input logic signed [ERR_W-1:0] x,
                                                         input logic [5:0] s);
    int sc;
`ifdef COSTAS_LF_ROUND_EN
    logic signed [ERR_W:0] wide;
    logic signed [ERR_W:0] half;
`endif
    sc = (int'(s) > ERR_W - 1) ? ERR_W - 1 : int'(s);
`ifdef COSTAS_LF_ROUND_EN
    half = '0;
    if (sc > 0) half = {{ERR_W{1'b0}}, 1'b1} << (sc - 1);
    wide = $signed({x[ERR_W-1], x}) + half;
    wide = wide >>> sc;
    return wide[ERR_W-1:0];
`else
    return x >>> sc;
`endif
  endfunction

  // Negating the most negative value leaves its MSB set, which flags the clamp case.
  function automatic logic [ERR_W-2:0] err_mag(input logic signed [ERR_W-1:0] x);
    logic [ERR_W-1:0] m;
    m = x[ERR_W-1] ? -x : x;
    if (m[ERR_W-1]) return '1;
    return m[ERR_W-2:0];
  endfunction

  always_comb begin
    kp_sel = (state == TRACK) ? trk_kp_shift : acq_kp_shift;
    ki_sel = (state == TRACK) ? trk_ki_shift : acq_ki_shift;
    mag    = err_mag(bus.err_in);
    hit    = (state == TRACK) ? (mag >= lock_thresh) : (mag < lock_thresh);
  end

  // Clear beats freeze beats the increment; the output always uses the updated acc.
  always_comb begin
    acc_sum = WIDE'(acc) + WIDE'(inc_r);
    if (integ_clr)   acc_sum = '0;
    else if (freeze) acc_sum = WIDE'(acc);
    acc_clip = 1'b0;
    acc_next = acc_sum[ACC_W-1:0];
    if (acc_sum > ACC_MAX) begin
      acc_next = ACC_MAX[ACC_W-1:0];
      acc_clip = 1'b1;
    end else if (acc_sum < ACC_MIN) begin
      acc_next = ACC_MIN[ACC_W-1:0];
      acc_clip = 1'b1;
    end
    corr_sum  = WIDE'(p_r) + WIDE'(acc_next);
    corr_clip = 1'b0;
    corr_next = corr_sum[OUT_W-1:0];
    if (corr_sum > OUT_MAX) begin
      corr_next = OUT_MAX[OUT_W-1:0];
      corr_clip = 1'b1;
    end else if (corr_sum < OUT_MIN) begin
      corr_next = OUT_MIN[OUT_W-1:0];
      corr_clip = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACQ;
      lock_cnt   <= '0;
      bus.locked <= 1'b0;
    end else if (bus.err_valid) begin
      if (!hit) begin
        lock_cnt <= '0;
      end else if (lock_cnt == CNT_W'(LOCK_CNT - 1)) begin
        lock_cnt   <= '0;
        state      <= (state == ACQ) ? TRACK : ACQ;
        bus.locked <= (state == ACQ);
      end else begin
        lock_cnt <= lock_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1             <= 1'b0;
      p_r            <= '0;
      inc_r          <= '0;
      acc            <= '0;
      bus.out_valid  <= 1'b0;
      bus.correction <= '0;
      bus.sat_flag   <= 1'b0;
    end else begin
      v1 <= bus.err_valid;
      if (bus.err_valid) begin
        p_r   <= gain_shift(bus.err_in, kp_sel);
        inc_r <= gain_shift(bus.err_in, ki_sel);
      end
      if (v1 || integ_clr) acc <= acc_next;
      bus.out_valid <= v1;
      if (v1) begin
        bus.correction <= corr_next;
        bus.sat_flag   <= acc_clip | corr_clip;
      end
    end
  end

endmodule

// File: tb/tb_costas_loop_filter.sv
// Scoreboard bench for costas_loop_filter: directed and random samples are run through an
// arithmetic reference model; a negedge monitor pops and compares every output pulse.
module tb_costas_loop_filter;

  localparam int ERR_W    = 64;
  localparam int OUT_W    = 32;
  localparam int ACC_W    = 40;
  localparam int LOCK_CNT = 16;

  typedef logic signed [127:0] wide_t;
  typedef struct {
    wide_t corr;
    bit    sat;
    bit    lck;
    int    cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [5:0]       acq_kp_shift;
  logic [5:0]       acq_ki_shift;
  logic [5:0]       trk_kp_shift;
  logic [5:0]       trk_ki_shift;
  logic [ERR_W-2:0] lock_thresh;
  logic             integ_clr;
  logic             freeze;

  costas_loop_filter_if #(.ERR_W(ERR_W), .OUT_W(OUT_W)) bus ();

  costas_loop_filter #(
    .ERR_W(ERR_W), .OUT_W(OUT_W), .ACC_W(ACC_W), .LOCK_CNT(LOCK_CNT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .acq_kp_shift(acq_kp_shift),
    .acq_ki_shift(acq_ki_shift),
    .trk_kp_shift(trk_kp_shift),
    .trk_ki_shift(trk_ki_shift),
    .lock_thresh(lock_thresh),
    .integ_clr(integ_clr),
    .freeze(freeze)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    n_checks = 0;
  int    n_pass = 0;
  exp_t  exp_q[$];

  int    cfg_acq_kp = 0, cfg_acq_ki = 0, cfg_trk_kp = 0, cfg_trk_ki = 0;
  wide_t cfg_thresh = 100;

  wide_t m_acc = 0, pend_p = 0, pend_inc = 0;
  bit    m_track = 0, pend_valid = 0;
  int    m_cnt = 0;

  task automatic checkOutput(input string name, input wide_t act, input wide_t expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
  endtask

  // floor(x / 2^s), or floor((x + 2^(s-1)) / 2^s) when rounding is enabled
  function automatic wide_t floor_shift(input wide_t x, input int s);
    wide_t d, q, y;
    d = wide_t'(1) <<< s;
    y = x;
`ifdef COSTAS_LF_ROUND_EN
    if (s > 0) y = y + d / 2;
`endif
    q = y / d;
    if (y < 0 && q * d != y) q = q - 1;
    return q;
  endfunction

  function automatic wide_t clampw(input wide_t v, input int w);
    wide_t lim;
    lim = wide_t'(1) <<< (w - 1);
    if (v > lim - 1) return lim - 1;
    if (v < -lim) return -lim;
    return v;
  endfunction

  // One model step per clock edge: finish last edge's sample, then accept this edge's.
  task automatic model_step(input bit v, input wide_t e, input bit clr, input bit frz);
    exp_t  x;
    bit    have;
    wide_t sum, nacc, corr, mag, top;
    int    kp, ki;
    bit    hit;
    have = pend_valid;
    if (pend_valid) begin
      sum   = clr ? 0 : (frz ? m_acc : m_acc + pend_inc);
      nacc  = clampw(sum, ACC_W);
      corr  = clampw(pend_p + nacc, OUT_W);
      x.corr = corr;
      x.sat  = (nacc != sum) || (corr != pend_p + nacc);
      m_acc  = nacc;
    end else if (clr) begin
      m_acc = 0;
    end
    pend_valid = v;
    if (v) begin
      kp = m_track ? cfg_trk_kp : cfg_acq_kp;
      ki = m_track ? cfg_trk_ki : cfg_acq_ki;
      if (kp > ERR_W - 1) kp = ERR_W - 1;
      if (ki > ERR_W - 1) ki = ERR_W - 1;
      pend_p   = floor_shift(e, kp);
      pend_inc = floor_shift(e, ki);
      top = (wide_t'(1) <<< (ERR_W - 1)) - 1;
      mag = (e < 0) ? -e : e;
      if (mag > top) mag = top;
      hit = m_track ? (mag >= cfg_thresh) : (mag < cfg_thresh);
      m_cnt = hit ? m_cnt + 1 : 0;
      if (m_cnt == LOCK_CNT) begin
        m_track = !m_track;
        m_cnt   = 0;
      end
    end
    if (have) begin
      x.lck = m_track;
      x.cyc = cyc + 1;
      exp_q.push_back(x);
    end
  endtask

  task automatic applyStimulus(input bit v, input logic signed [ERR_W-1:0] e,
                               input bit clr, input bit frz);
    @(posedge clk);
    #1;
    acq_kp_shift  = 6'(cfg_acq_kp);
    acq_ki_shift  = 6'(cfg_acq_ki);
    trk_kp_shift  = 6'(cfg_trk_kp);
    trk_ki_shift  = 6'(cfg_trk_ki);
    lock_thresh   = cfg_thresh[ERR_W-2:0];
    bus.err_valid = v;
    bus.err_in    = e;
    integ_clr     = clr;
    freeze        = frz;
    model_step(v, wide_t'(e), clr, frz);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0);
  endtask

  // Only called after idle cycles, so the skipped edge leaves the model unchanged.
  task automatic checkAcc(input string name);
    @(posedge clk);
    #2;
    checkOutput(name, wide_t'(dut.acc), m_acc);
  endtask

  task automatic doReset();
    #2;
    rst_n         = 1'b0;
    bus.err_valid = 1'b0;
    integ_clr     = 1'b0;
    freeze        = 1'b0;
    exp_q.delete();
    m_acc = 0; m_track = 0; m_cnt = 0; pend_valid = 0;
    #1;
    checkOutput("reset_correction", wide_t'(bus.correction), 0);
    checkOutput("reset_out_valid", wide_t'(bus.out_valid), 0);
    checkOutput("reset_locked", wide_t'(bus.locked), 0);
    checkOutput("reset_sat_flag", wide_t'(bus.sat_flag), 0);
    checkOutput("reset_acc", wide_t'(dut.acc), 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  function automatic logic signed [ERR_W-1:0] pickErr();
    int r;
    int t;
    r = $urandom_range(0, 9);
    case (r)
      0, 1, 2, 3, 4: begin
        t = int'($urandom_range(0, 400)) - 200;
        return ERR_W'(t);
      end
      5, 6:    return {$urandom, $urandom};
      7:       return {1'b0, {(ERR_W-1){1'b1}}};
      8:       return {1'b1, {(ERR_W-1){1'b0}}};
      default: begin
        t = int'($urandom);
        return ERR_W'(t);
      end
    endcase
  endfunction

  initial begin : monitor
    exp_t  e;
    wide_t hold_corr;
    hold_corr = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_corr = 0;
      end else if (bus.out_valid) begin
        checkOutput("expected_pulse", wide_t'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checkOutput("latency_cycle", wide_t'(cyc), wide_t'(e.cyc));
          checkOutput("correction", wide_t'(bus.correction), e.corr);
          checkOutput("sat_flag", wide_t'(bus.sat_flag), wide_t'(e.sat));
          checkOutput("locked", wide_t'(bus.locked), wide_t'(e.lck));
          hold_corr = e.corr;
        end
      end else begin
        checkOutput("hold_correction", wide_t'(bus.correction), hold_corr);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    bus.err_valid = 1'b0;
    bus.err_in    = '0;
    integ_clr     = 1'b0;
    freeze        = 1'b0;
    acq_kp_shift  = '0;
    acq_ki_shift  = '0;
    trk_kp_shift  = '0;
    trk_ki_shift  = '0;
    lock_thresh   = '0;
    doReset();

    $display("[TB] basic PI sample");
    cfg_acq_kp = 4; cfg_acq_ki = 8; cfg_trk_kp = 2; cfg_trk_ki = 10; cfg_thresh = 100;
    applyStimulus(1'b1, 64'sd4096, 1'b0, 1'b0);
    idle(2);
    checkAcc("acc_after_first");

    $display("[TB] saturation then integrator clear");
    cfg_acq_kp = 0; cfg_acq_ki = 0;
    applyStimulus(1'b1, 64'sh4000_0000_0000_0000, 1'b0, 1'b0);
    applyStimulus(1'b1, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    idle(2);
    checkAcc("acc_after_clear");

    $display("[TB] negative shift rounding with held integrator");
    cfg_acq_kp = 1; cfg_acq_ki = 63;
    applyStimulus(1'b1, -64'sd3, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    idle(2);

    $display("[TB] lock and unlock sequence");
    doReset();
    cfg_acq_kp = 4; cfg_acq_ki = 8; cfg_trk_kp = 2; cfg_trk_ki = 10; cfg_thresh = 100;
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 64'sd50, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 64'sd200, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'sd50, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 64'sd200, 1'b0, 1'b0);
    idle(2);

    $display("[TB] frozen integrator stream and mid-stream reset");
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 64'sd1000, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    idle(2);
    checkAcc("acc_frozen");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 64'sd1000, 1'b0, 1'b1);
    doReset();
    idle(3);
    applyStimulus(1'b1, 64'sd4096, 1'b0, 1'b0);
    idle(2);

    $display("[TB] randomized stream");
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) begin
        cfg_acq_kp = $urandom_range(0, 63);
        cfg_acq_ki = $urandom_range(0, 63);
        cfg_trk_kp = $urandom_range(0, 63);
        cfg_trk_ki = $urandom_range(0, 63);
        cfg_thresh = $urandom_range(20, 300);
      end
      applyStimulus($urandom_range(0, 3) != 0, pickErr(),
                    $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0);
    end
    idle(4);
    checkAcc("acc_after_random");

    checkOutput("scoreboard_drained", wide_t'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
